sync_serial_rx: RTL and testbench
=================================

Name: sync_serial_rx

Overview:
Receive end of the two-wire synchronous serial link (serial data plus serial clock) driven by the uart_codec transmitter. The block samples rxsd on rising edges of rxck in the 100 MHz clk domain, deframes start/data/stop words, and holds each received word for the display/LED logic. It provides read handshake, frame-error, overrun and timeout detection, and a frame counter. It sits beside the transmitter inside the codec top and is exercised by the board-level loopback (txsd->rxsd, txck->rxck).

Parameters:
DATA_W, 16, data bits per frame (sent LSB first)
TIMEOUT_CYC, 100000, clk cycles with no rxck rising edge mid-frame before the frame is aborted (1 ms at 100 MHz)
CNT_W, 8, width of good-frame counter

Ports:
clk  input  1  100 MHz system clock
btnl  input  1  reset; synchronous, active-high
rxsd  input  1  serial data, asynchronous to clk; idle high
rxck  input  1  serial clock, asynchronous to clk; data valid at its rising edge
rd_ack  input  1  consumer acknowledges rx_data; clears rx_full
rx_data  output  DATA_W  last good received word
rx_valid  output  1  one-clk pulse when a good frame is loaded
rx_full  output  1  rx_data holds an unacknowledged word
rx_frame_err  output  1  sticky: bad stop bit or timeout
rx_overrun  output  1  sticky: good frame arrived while rx_full=1
rx_busy  output  1  FSM not in IDLE
rx_cnt  output  CNT_W  count of good frames loaded, wraps

Behaviour:
- Reset (btnl=1 at a clk edge): all outputs 0, FSM=IDLE, synchronizers cleared to 0, bit index/timeout counter 0. Reset mid-frame discards the partial frame.
- Sync: rxck and rxsd each pass through 2 flops (s1, s2); rxck_s3 is one more flop. edge = rxck_s2 & ~rxck_s3; sampled bit = rxsd_s2.
- Latency: an rxck rising edge captured by s1 at clk edge k is acted on by the FSM at edge k+2; registered outputs change at k+2.
- Link timing requirement: rxck high and low each >= 3 clk periods; rxsd stable from 3 clk before to 3 clk after each rxck rise.
- FSM:
  IDLE: on edge with bit=0 -> DATA, bit_idx=0, timeout counter cleared. Edge with bit=1 ignored.
  DATA: on edge, shift register <= {bit, shreg[DATA_W-1:1]}; bit_idx++; after DATA_W bits -> STOP.
  STOP: on edge: bit=1 -> good frame; bit=0 -> rx_frame_err<=1, word dropped. Either way -> IDLE.
  DATA/STOP: timeout counter increments each clk without edge and clears on edge; reaching TIMEOUT_CYC-1 -> IDLE, rx_frame_err<=1, word dropped.
- Good frame:
  rx_full=0 or rd_ack=1 same cycle: rx_data<=word, rx_valid=1 for one clk, rx_full<=1, rx_cnt++ (wraps from 2^CNT_W-1 to 0).
  rx_full=1 and rd_ack=0: rx_overrun<=1, rx_data unchanged, rx_cnt unchanged, no rx_valid.
- rd_ack with no good frame same cycle: rx_full<=0; rx_data retains value. rd_ack while rx_full=0 has no effect.
- rx_frame_err and rx_overrun clear only on reset.
- rx_busy = (state != IDLE), registered with state.

Test Plan:
- Frame 0xA5C3 (start 0, LSB first, stop 1), rxck period 20 clk -> rx_data=0xA5C3, single-cycle rx_valid 3 clk after the stop-bit rxck rise, rx_full=1, rx_cnt=1, no error flags.
- Frame 0x1234 with stop bit 0 -> rx_frame_err=1, rx_data/rx_cnt/rx_full unchanged, FSM back to IDLE; next good frame 0x00FF is received normally.
- Two good frames 0x1111 then 0x2222, no rd_ack -> rx_overrun=1, rx_data=0x1111, rx_cnt=1; rd_ack pulse -> rx_full=0.
- rxck stopped after 5 data bits for TIMEOUT_CYC clk (parameter set to 50) -> IDLE at cycle 50, rx_frame_err=1, rx_busy=0; following frame 0xBEEF received correctly.
- rd_ack asserted in the same cycle the second good frame 0x3333 loads -> rx_data=0x3333, rx_full=1, rx_overrun=0, rx_cnt=2.
- btnl asserted mid-frame after 8 bits -> all outputs 0 next clk; remaining bits of that frame (no start bit) are ignored; next full frame 0x0F0F is received.

Source files
------------

// File: rtl/sync_serial_rx.sv
// Receive side of the rxsd/rxck synchronous serial link: synchronizes both wires into clk,
// deframes start/data/stop words and holds the last good word for a handshaking consumer.
module sync_serial_rx #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              btnl,
  input  logic              rxsd,
  input  logic              rxck,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_full,
  output logic              rx_frame_err,
  output logic              rx_overrun,
  output logic              rx_busy,
  output logic [CNT_W-1:0]  rx_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  logic              r_rxck_s1, r_rxck_s2, r_rxck_s3;
  logic              r_rxsd_s1, r_rxsd_s2;
  logic              w_edge;
  logic              w_bit;
  logic              w_timeout;

  state_t            r_state;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_full;
  logic              r_frame_err;
  logic              r_overrun;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;

  // Two-flop synchronizers; the third rxck flop only feeds rising-edge detection.
  always_ff @(posedge clk) begin
    if (btnl) begin
      r_rxck_s1 <= 1'b0;
      r_rxck_s2 <= 1'b0;
      r_rxck_s3 <= 1'b0;
      r_rxsd_s1 <= 1'b0;
      r_rxsd_s2 <= 1'b0;
    end else begin
      r_rxck_s1 <= rxck;
      r_rxck_s2 <= r_rxck_s1;
      r_rxck_s3 <= r_rxck_s2;
      r_rxsd_s1 <= rxsd;
      r_rxsd_s2 <= r_rxsd_s1;
    end
  end

  assign w_edge    = r_rxck_s2 & ~r_rxck_s3;
  assign w_bit     = r_rxsd_s2;
  assign w_timeout = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (btnl) begin
      r_state     <= S_IDLE;
      r_bit_idx   <= '0;
      r_to_cnt    <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_full      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_valid <= 1'b0;
      // A load in the same cycle overrides this clear further down.
      if (rd_ack) begin
        r_full <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_edge && !w_bit) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_to_cnt  <= '0;
            r_busy    <= 1'b1;
          end
        end

        S_DATA: begin
          if (w_edge) begin
            r_shreg  <= {w_bit, r_shreg[DATA_W-1:1]};
            r_to_cnt <= '0;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_edge) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_to_cnt <= '0;
            if (!w_bit) begin
              r_frame_err <= 1'b1;
            end else if (!r_full || rd_ack) begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
              r_full  <= 1'b1;
              r_cnt   <= r_cnt + 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_full      = r_full;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;
  assign rx_busy      = r_busy;
  assign rx_cnt       = r_cnt;

endmodule

// File: tb/tb_sync_serial_rx.sv
// Bench for sync_serial_rx: table of whole-frame vectors plus hand-written timeout,
// same-cycle acknowledge and mid-frame reset sequences; received words checked via a scoreboard.
module tb_sync_serial_rx;

  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 50;
  localparam int CNT_W       = 8;

  logic              clk;
  logic              btnl;
  logic              rxsd;
  logic              rxck;
  logic              rd_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_full;
  logic              rx_frame_err;
  logic              rx_overrun;
  logic              rx_busy;
  logic [CNT_W-1:0]  rx_cnt;

  int n_checks = 0;
  int n_err    = 0;
  logic [DATA_W-1:0] sb_q[$];

  sync_serial_rx #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .btnl         (btnl),
    .rxsd         (rxsd),
    .rxck         (rxck),
    .rd_ack       (rd_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_full      (rx_full),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy),
    .rx_cnt       (rx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected_valid: got rx_data %0h expected no word at %0t", rx_data, $time);
      end else begin
        chk("sb_data", 32'(rx_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    btnl = 1'b1;
    repeat (2) @(negedge clk);
    btnl = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  // One 20-clk bit slot: rxsd set, rxck rises 4 clk later, high 10 clk, low 5 clk.
  task automatic send_bit(input logic b, input logic lat_check, input logic ack_load);
    @(negedge clk);
    rxsd = b;
    repeat (4) @(negedge clk);
    rxck = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (lat_check && i <= 4) chk($sformatf("valid_latency_%0d", i), 32'(rx_valid), (i == 3) ? 32'd1 : 32'd0);
      if (ack_load && i == 2) rd_ack = 1'b1;
      if (ack_load && i == 3) rd_ack = 1'b0;
    end
    rxck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop,
                            input logic lat_check, input logic ack_load);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(w[i], 1'b0, 1'b0);
    send_bit(stop, lat_check, ack_load);
    rxsd = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic [DATA_W-1:0] d, input logic full,
                         input logic err, input logic ovr, input logic [CNT_W-1:0] cnt,
                         input logic busy);
    chk({tag, "_data"}, 32'(rx_data), 32'(d));
    chk({tag, "_full"}, 32'(rx_full), 32'(full));
    chk({tag, "_err"},  32'(rx_frame_err), 32'(err));
    chk({tag, "_ovr"},  32'(rx_overrun), 32'(ovr));
    chk({tag, "_cnt"},  32'(rx_cnt), 32'(cnt));
    chk({tag, "_busy"}, 32'(rx_busy), 32'(busy));
  endtask

  typedef struct {
    logic              rst_before;
    logic              ack_before;
    logic [DATA_W-1:0] word;
    logic              stop;
    logic              loads;
    logic              lat;
    logic [DATA_W-1:0] e_data;
    logic              e_full;
    logic              e_err;
    logic              e_ovr;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] part;
    //              rst   ackb  word      stop  loads lat   e_data    full  err   ovr   cnt
    vecs[0] = '{1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[1] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[2] = '{1'b0, 1'b0, 16'h00FF, 1'b1, 1'b1, 1'b0, 16'h00FF, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[3] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[4] = '{1'b0, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b1, 8'd1};

    btnl   = 1'b1;
    rxsd   = 1'b1;
    rxck   = 1'b0;
    rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    btnl = 1'b0;
    @(negedge clk);
    chk_all("reset", '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("reset_valid", 32'(rx_valid), 32'd0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].rst_before) do_reset();
      if (vecs[v].ack_before) pulse_ack();
      if (vecs[v].loads) sb_q.push_back(vecs[v].word);
      send_frame(vecs[v].word, vecs[v].stop, vecs[v].lat, 1'b0);
      chk_all($sformatf("vec%0d", v), vecs[v].e_data, vecs[v].e_full, vecs[v].e_err,
              vecs[v].e_ovr, vecs[v].e_cnt, 1'b0);
    end
    pulse_ack();
    chk("ack_clears_full", 32'(rx_full), 32'd0);
    chk("ack_keeps_data", 32'(rx_data), 32'h1111);

    // rd_ack lands in exactly the cycle the second word loads.
    do_reset();
    sb_q.push_back(16'h1111);
    send_frame(16'h1111, 1'b1, 1'b0, 1'b0);
    sb_q.push_back(16'h3333);
    send_frame(16'h3333, 1'b1, 1'b0, 1'b1);
    chk_all("ack_same_cycle", 16'h3333, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0);

    // rxck stops after start + 5 data bits; frame must abort after TIMEOUT_CYC idle clocks.
    do_reset();
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    repeat (25) @(negedge clk);
    chk("timeout_pending_busy", 32'(rx_busy), 32'd1);
    chk("timeout_pending_err", 32'(rx_frame_err), 32'd0);
    repeat (30) @(negedge clk);
    chk("timeout_busy", 32'(rx_busy), 32'd0);
    chk("timeout_err", 32'(rx_frame_err), 32'd1);
    sb_q.push_back(16'hBEEF);
    send_frame(16'hBEEF, 1'b1, 1'b0, 1'b0);
    chk_all("after_timeout", 16'hBEEF, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);

    // Reset after 8 data bits; the remaining all-ones bits carry no start bit.
    do_reset();
    sb_q.push_back(16'h5A5A);
    send_frame(16'h5A5A, 1'b1, 1'b0, 1'b0);
    part = 16'hFF00;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(part[i], 1'b0, 1'b0);
    @(negedge clk);
    btnl = 1'b1;
    @(negedge clk);
    btnl = 1'b0;
    chk_all("midframe_reset", '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 8; i < DATA_W; i++) send_bit(part[i], 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk_all("tail_ignored", '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    sb_q.push_back(16'h0F0F);
    send_frame(16'h0F0F, 1'b1, 1'b0, 1'b0);
    chk_all("after_reset", 16'h0F0F, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
